// File: rtl/branch_predictor.sv
// Direct-mapped branch target predictor with 2-bit saturating counters.
// Zero-latency lookup for fetch, trained by resolved outcomes from execute.
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_branch,
   input  logic        upd_jump,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        mispredict,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int TAG_W = 30 - IDX_W;

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];
   logic             jump_q   [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             lk_hit, up_hit;
   logic             qualified, actual_taken, mispredict_raw;

   assign lk_idx = if_pc[IDX_W+1:2];
   assign lk_tag = if_pc[31:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[31:IDX_W+2];

   // Lookup reads registered contents only, so a same-cycle update is seen next cycle.
   assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign pred_taken  = rst_n && lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
   assign pred_target = pred_taken ? target_q[lk_idx] : (if_pc + 32'd4);

   assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign qualified    = upd_valid && (upd_branch || upd_jump);
   assign actual_taken = upd_jump || (upd_branch && upd_taken);

   assign mispredict_raw = qualified &&
                           ((upd_pred_taken != actual_taken) ||
                            (actual_taken && (upd_pred_target != upd_target)));
   assign mispredict     = rst_n && mispredict_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            jump_q[i]   <= 1'b0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (qualified) begin
         if (up_hit) begin
            // Jumps train only target and is_jump; the counter follows conditional branches.
            if (upd_branch && !upd_jump) begin
               if (upd_taken && ctr_q[up_idx] != 2'b11)
                  ctr_q[up_idx] <= ctr_q[up_idx] + 2'b01;
               else if (!upd_taken && ctr_q[up_idx] != 2'b00)
                  ctr_q[up_idx] <= ctr_q[up_idx] - 2'b01;
            end
            if (actual_taken)
               target_q[up_idx] <= upd_target;
            jump_q[up_idx] <= upd_jump;
         end else if (actual_taken) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
            jump_q[up_idx]   <= upd_jump;
            ctr_q[up_idx]    <= upd_jump ? 2'b11 : 2'b10;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (qualified) begin
         if (branch_count != 32'hFFFF_FFFF)
            branch_count <= branch_count + 32'd1;
         if (mispredict_raw && mispredict_count != 32'hFFFF_FFFF)
            mispredict_count <= mispredict_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: per-cycle lookup/update records
// with hand-computed predictions, mispredict flags and statistics.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid, upd_branch, upd_jump, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic        mispredict;
   logic [31:0] branch_count, mispredict_count;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_branch(upd_branch),
      .upd_jump(upd_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict), .branch_count(branch_count),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ipc;
      logic        uv, ub, uj, ut;
      logic [31:0] upc, utgt;
      logic        upt;
      logic [31:0] uptgt;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_mp;
      logic [31:0] e_bc, e_mc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [31:0] ipc, logic uv, logic ub, logic uj, logic ut,
                               logic [31:0] upc, logic [31:0] utgt, logic upt, logic [31:0] uptgt,
                               logic e_pt, logic [31:0] e_ptgt, logic e_mp,
                               logic [31:0] e_bc, logic [31:0] e_mc);
      vec_t v;
      v.ipc = ipc; v.uv = uv; v.ub = ub; v.uj = uj; v.ut = ut;
      v.upc = upc; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
      v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mp = e_mp; v.e_bc = e_bc; v.e_mc = e_mc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic idle_upd();
      upd_valid = 0; upd_branch = 0; upd_jump = 0; upd_taken = 0;
      upd_pc = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
   endtask

   initial begin
      //         if_pc         uv b  j  t  upd_pc        upd_tgt       pt pred_tgt      | pt tgt          mp bc  mc
      vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      0, 32'h104,     0, 0,  0));
      vecs.push_back(mk(32'h100, 1, 1, 0, 1, 32'h100,     32'h080,      0, 32'h104,      0, 32'h104,     1, 1,  1));
      vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      1, 32'h080,     0, 1,  1));
      vecs.push_back(mk(32'h100, 1, 1, 0, 0, 32'h100,     32'h080,      1, 32'h080,      1, 32'h080,     1, 2,  2));
      vecs.push_back(mk(32'h100, 1, 1, 0, 0, 32'h100,     32'h080,      0, 32'h104,      0, 32'h104,     0, 3,  2));
      vecs.push_back(mk(32'h100, 1, 1, 0, 0, 32'h100,     32'h080,      0, 32'h104,      0, 32'h104,     0, 4,  2));
      vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      0, 32'h104,     0, 4,  2));
      // alias on index 0
      vecs.push_back(mk(32'h140, 1, 1, 0, 1, 32'h140,     32'h500,      0, 32'h144,      0, 32'h144,     1, 5,  3));
      vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      0, 32'h104,     0, 5,  3));
      vecs.push_back(mk(32'h140, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      1, 32'h500,     0, 5,  3));
      vecs.push_back(mk(32'h140, 1, 1, 0, 0, 32'h180,     32'h999,      0, 32'h184,      1, 32'h500,     0, 6,  3));
      vecs.push_back(mk(32'h180, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      0, 32'h184,     0, 6,  3));
      vecs.push_back(mk(32'h140, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      1, 32'h500,     0, 6,  3));
      // jump allocation and target retraining
      vecs.push_back(mk(32'h200, 1, 0, 1, 0, 32'h200,     32'h300,      0, 32'h204,      0, 32'h204,     1, 7,  4));
      vecs.push_back(mk(32'h200, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      1, 32'h300,     0, 7,  4));
      vecs.push_back(mk(32'h200, 1, 0, 1, 1, 32'h200,     32'h340,      1, 32'h300,      1, 32'h300,     1, 8,  5));
      vecs.push_back(mk(32'h200, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      1, 32'h340,     0, 8,  5));
      vecs.push_back(mk(32'h200, 1, 0, 0, 1, 32'h200,     32'h777,      0, 32'h000,      1, 32'h340,     0, 8,  5));
      vecs.push_back(mk(32'h200, 1, 0, 1, 1, 32'h200,     32'h340,      1, 32'h340,      1, 32'h340,     0, 9,  5));
      vecs.push_back(mk(32'h200, 0, 1, 0, 1, 32'h100,     32'h080,      0, 32'h104,      1, 32'h340,     0, 9,  5));
      vecs.push_back(mk(32'h100, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      0, 32'h104,     0, 9,  5));
      vecs.push_back(mk(32'hFFFF_FFFC, 0, 0, 0, 0, 32'h000, 32'h000,    0, 32'h000,      0, 32'h000,     0, 9,  5));
      // branch and jump both set: jump wins, not-taken flag ignored
      vecs.push_back(mk(32'h204, 1, 1, 1, 0, 32'h204,     32'h400,      0, 32'h208,      0, 32'h208,     1, 10, 6));
      vecs.push_back(mk(32'h204, 0, 0, 0, 0, 32'h000,     32'h000,      0, 32'h000,      1, 32'h400,     0, 10, 6));

      rst_n = 0; if_pc = 32'h100; idle_upd();
      #12;
      chk("reset_pred_taken", -1, {31'd0, pred_taken}, 32'd0);
      chk("reset_mispredict", -1, {31'd0, mispredict}, 32'd0);
      chk("reset_branch_count", -1, branch_count, 32'd0);
      @(negedge clk); rst_n = 1;

      foreach (vecs[i]) begin
         @(negedge clk);
         if_pc = vecs[i].ipc;
         upd_valid = vecs[i].uv; upd_branch = vecs[i].ub; upd_jump = vecs[i].uj;
         upd_taken = vecs[i].ut; upd_pc = vecs[i].upc; upd_target = vecs[i].utgt;
         upd_pred_taken = vecs[i].upt; upd_pred_target = vecs[i].uptgt;
         #1;
         chk("pred_taken", i, {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
         chk("pred_target", i, pred_target, vecs[i].e_ptgt);
         chk("mispredict", i, {31'd0, mispredict}, {31'd0, vecs[i].e_mp});
         @(posedge clk); #1;
         chk("branch_count", i, branch_count, vecs[i].e_bc);
         chk("mispredict_count", i, mispredict_count, vecs[i].e_mc);
      end

      // Asynchronous reset mid-cycle while an update is presented.
      @(negedge clk);
      if_pc = 32'h204;
      upd_valid = 1; upd_branch = 1; upd_jump = 0; upd_taken = 1;
      upd_pc = 32'h300; upd_target = 32'h600; upd_pred_taken = 0; upd_pred_target = 32'h304;
      #1;
      chk("pre_rst_mispredict", 100, {31'd0, mispredict}, 32'd1);
      chk("pre_rst_pred_taken", 100, {31'd0, pred_taken}, 32'd1);
      #1 rst_n = 0;
      #1;
      chk("async_rst_pred_taken", 101, {31'd0, pred_taken}, 32'd0);
      chk("async_rst_pred_target", 101, pred_target, 32'h208);
      chk("async_rst_mispredict", 101, {31'd0, mispredict}, 32'd0);
      chk("async_rst_branch_count", 101, branch_count, 32'd0);
      chk("async_rst_mispredict_count", 101, mispredict_count, 32'd0);
      idle_upd();
      @(negedge clk); rst_n = 1;
      @(negedge clk); #1;
      chk("post_rst_lookup", 102, {31'd0, pred_taken}, 32'd0);
      if_pc = 32'h200; #1;
      chk("post_rst_target", 102, pred_target, 32'h204);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to execute-stage branch resolution in the pipelined RV32I core.
- Predicts taken/target for the current fetch PC from a direct-mapped table of entries. Each entry holds valid, tag, target, is_jump and a 2-bit saturating counter.
- Is trained by the resolved outcome returned from execute (branch/jump/taken/target).
- Flags mispredicts for pipeline flush and keeps branch/mispredict statistics.

Parameters:
- ENTRIES, 16, number of table entries; power of two, 2..256.
- IDX_W, $clog2(ENTRIES), derived index width. Index = pc[IDX_W+1:2].
- TAG_W = 30-IDX_W, derived. Tag = pc[31:IDX_W+2].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  fetch-stage PC for lookup
- pred_taken  out  1  predicted redirect for if_pc
- pred_target  out  32  predicted next PC
- upd_valid  in  1  execute-stage resolution valid this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_branch  in  1  instruction is a conditional branch
- upd_jump  in  1  instruction is JAL/JALR
- upd_taken  in  1  resolved branch_taken from execute
- upd_target  in  32  resolved target address
- upd_pred_taken  in  1  prediction made at fetch, piped down
- upd_pred_target  in  32  predicted target, piped down
- mispredict  out  1  combinational flush request
- branch_count  out  32  resolved branch+jump count
- mispredict_count  out  32  mispredict count

Behaviour:
- Reset (async, rst_n=0): all valid bits cleared, counters set to 2'b01, is_jump cleared, branch_count and mispredict_count set to 0. mispredict=0 and pred_taken=0 while in reset. Deassertion is synchronous to clk in the surrounding logic. Reset mid-operation discards all training immediately.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx]==if_pc tag).
  - pred_taken = hit & (is_jump[idx] | ctr[idx][1]).
  - pred_target = pred_taken ? target[idx] : if_pc+32'd4 (wraps modulo 2^32).
- actual_taken = upd_jump | (upd_branch & upd_taken). upd_jump has priority when both upd_jump and upd_branch are set.
- Training: at the posedge, only when upd_valid & (upd_branch|upd_jump).
  - Update hit (same index and tag):
    - Branch: counter saturating +1 if upd_taken, -1 otherwise; 2'b11 and 2'b00 hold.
    - Target is overwritten with upd_target when actual_taken.
    - is_jump is set to upd_jump.
  - Update miss and actual_taken:
    - Allocate, overwriting any alias: valid=1, tag, target=upd_target, is_jump=upd_jump.
    - Counter = 2'b10 for a branch, 2'b11 for a jump.
  - Update miss and not taken: no allocation, table unchanged.
  - upd_valid with neither branch nor jump: no table or statistics effect.
- mispredict (combinational) = upd_valid & (upd_branch|upd_jump) & ((upd_pred_taken != actual_taken) | (actual_taken & upd_pred_target != upd_target)).
- Statistics, per qualified update:
  - branch_count increments by 1.
  - mispredict_count increments by 1 when mispredict is set.
  - Both saturate at 32'hFFFF_FFFF.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (no bypass). The new contents are visible from the next cycle.
- Single write port; one update per cycle maximum.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104, both counts 0, mispredict=0.
- Update pc=0x100, branch, taken, target=0x080, pred_taken=0 -> mispredict=1 that cycle. Next cycle with if_pc=0x100: pred_taken=1, pred_target=0x080, branch_count=1, mispredict_count=1.
- Same branch resolved not-taken three times (pred_taken matching the prediction each time) -> counter 10->01->00->00. pred_taken=0 after the first update. mispredict=1 only on the first update.
- Jump pc=0x200, target=0x300, then lookup 0x200 -> pred_taken=1 regardless of counter. Resolve again with upd_target=0x340, pred_target=0x300 -> mispredict=1 and target updated to 0x340.
- Alias (ENTRIES=16): train 0x100 taken->0x080, then train 0x140 taken->0x500 -> lookup 0x100 misses (pred_target=0x104), lookup 0x140 returns 0x500. A not-taken miss at 0x180 allocates nothing.
- Update and lookup of 0x100 in the same cycle -> old prediction this cycle, new one next cycle. Assert rst_n=0 mid-run -> outputs and counts clear asynchronously before the next clk edge.
